// File: rtl/sincronizador_vga_pkg.sv
// Shared VGA 640x480@60 timing constants. Used by the sync generator and
// by the text generator so both agree on the raster geometry.
package sincronizador_vga_pkg;

   localparam int DIV_PIX_DEF = 4;    // 100 MHz clk -> 25 MHz pixel rate

   localparam int H_DISP_DEF  = 640;
   localparam int H_FP_DEF    = 16;
   localparam int H_SYNC_DEF  = 96;
   localparam int H_BP_DEF    = 48;

   localparam int V_DISP_DEF  = 480;
   localparam int V_FP_DEF    = 10;
   localparam int V_SYNC_DEF  = 2;
   localparam int V_BP_DEF    = 33;

   // Derived raster constants for the default timing
   localparam int H_TOTAL      = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
   localparam int V_TOTAL      = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525
   localparam int H_SYNC_START = H_DISP_DEF + H_FP_DEF;                          // 656
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;                  // 751
   localparam int V_SYNC_START = V_DISP_DEF + V_FP_DEF;                          // 490
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;                  // 491

   // True when val lies in the inclusive window [lo, hi]; full 10-bit compare
   function automatic logic in_window(input logic [9:0] val,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/sincronizador_vga_divisor.sv
// Pixel-rate divider: free-running 0..DIV_PIX-1 counter, p_tick high while
// the counter sits at its last value.
module divisor_pixel #(
   parameter int DIV_PIX = 4
) (
   input  logic clk,
   input  logic reset,
   output logic p_tick
);

   localparam int W = (DIV_PIX > 1) ? $clog2(DIV_PIX) : 1;
   localparam logic [W-1:0] LAST = W'(DIV_PIX - 1);

   logic [W-1:0] cnt;

   // Divider counter; reset restarts the phase so the first tick lands
   // DIV_PIX-1 cycles after release
   always_ff @(posedge clk) begin
      if (reset)              cnt <= '0;
      else if (cnt == LAST)   cnt <= '0;
      else                    cnt <= cnt + 1'b1;
   end

   assign p_tick = (cnt == LAST);

endmodule

// File: rtl/sincronizador_vga.sv
// VGA sync generator: pixel divider, h/v raster counters and registered
// sync/blank decode that is cycle-aligned with pixel_x/pixel_y.
module sincronizador_vga
   import sincronizador_vga_pkg::*;
#(
   parameter int DIV_PIX = DIV_PIX_DEF,
   parameter int H_DISP  = H_DISP_DEF,
   parameter int H_FP    = H_FP_DEF,
   parameter int H_SYNC  = H_SYNC_DEF,
   parameter int H_BP    = H_BP_DEF,
   parameter int V_DISP  = V_DISP_DEF,
   parameter int V_FP    = V_FP_DEF,
   parameter int V_SYNC  = V_SYNC_DEF,
   parameter int V_BP    = V_BP_DEF
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_start
);

   // Decode boundaries come from this instance's parameters so a reduced
   // raster works with the same logic
   localparam logic [9:0] H_LAST   = 10'(H_DISP + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST   = 10'(V_DISP + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISP);
   localparam logic [9:0] V_VIS    = 10'(V_DISP);
   localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

   logic [9:0] h_q, v_q, h_next, v_next;
   logic       h_end, v_end;

   divisor_pixel #(.DIV_PIX(DIV_PIX)) u_div (
      .clk    (clk),
      .reset  (reset),
      .p_tick (p_tick)
   );

   assign h_end = (h_q == H_LAST);
   assign v_end = (v_q == V_LAST);

   // Next raster position: h steps on p_tick, v steps only on h wrap
   always_comb begin
      h_next = h_q;
      v_next = v_q;
      if (p_tick) begin
         if (h_end) begin
            h_next = '0;
            v_next = v_end ? '0 : v_q + 10'd1;
         end else begin
            h_next = h_q + 10'd1;
         end
      end
   end

   // Counters plus sync/blank registered from the decode of the values being
   // loaded, so outputs carry no skew relative to pixel_x/pixel_y
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q         <= '0;
         v_q         <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         h_q         <= h_next;
         v_q         <= v_next;
         hsync       <= ~in_window(h_next, HS_START, HS_END);
         vsync       <= ~in_window(v_next, VS_START, VS_END);
         video_on    <= (h_next < H_VIS) && (v_next < V_VIS);
         frame_start <= p_tick & h_end & v_end;
      end
   end

   assign pixel_x = h_q;
   assign pixel_y = v_q;

endmodule

// File: tb/tb_sincronizador_vga.sv
// Scoreboard bench for sincronizador_vga on a reduced raster
// (DIV 4, line 16+2+3+3=24 px, frame 6+2+2+2=12 lines, 1152 clk/frame).
module tb_sincronizador_vga;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hsync, vsync, video_on, p_tick, frame_start;
   logic [9:0] pixel_x, pixel_y;

   always #5 clk = ~clk;

   sincronizador_vga #(
      .DIV_PIX(4), .H_DISP(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_DISP(6),  .V_FP(2),    .V_SYNC(2), .V_BP(2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .p_tick      (p_tick),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .frame_start (frame_start)
   );

   typedef struct {
      int         tag;   // 0 = cycle model, 1 = hand vector
      int         t;
      logic [9:0] x, y;
      logic       hs, vs, vo, pt, fs;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   fs_seen = 0;
   bit   done = 0;

   // Cycle-count model: t = clk edges since the last reset edge
   function automatic exp_t model(input int t, input bit rst);
      exp_t e;
      int   pix;
      e.tag = 0; e.t = t;
      if (rst) begin
         e.x = 0; e.y = 0; e.hs = 1; e.vs = 1; e.vo = 0; e.pt = 0; e.fs = 0;
      end else begin
         pix  = t / 4;
         e.x  = 10'(pix % 24);
         e.y  = 10'((pix / 24) % 12);
         e.vo = (e.x < 16) && (e.y < 6);
         e.hs = !((e.x >= 18) && (e.x <= 20));
         e.vs = !((e.y >= 8) && (e.y <= 9));
         e.pt = (t % 4) == 3;
         e.fs = (t > 0) && ((t % 1152) == 0);
      end
      return e;
   endfunction

   // Hand-computed checkpoints: {x, y, hs, vs, vo, pt, fs}
   function automatic bit hand(input int t, output exp_t e);
      logic [24:0] v;
      bit hit = 1;
      case (t)
         0:    v = {10'd0,  10'd0,  5'b11000};
         1:    v = {10'd0,  10'd0,  5'b11100};
         3:    v = {10'd0,  10'd0,  5'b11110};
         4:    v = {10'd1,  10'd0,  5'b11100};
         7:    v = {10'd1,  10'd0,  5'b11110};
         8:    v = {10'd2,  10'd0,  5'b11100};
         63:   v = {10'd15, 10'd0,  5'b11110};
         64:   v = {10'd16, 10'd0,  5'b11000};
         71:   v = {10'd17, 10'd0,  5'b11010};
         72:   v = {10'd18, 10'd0,  5'b01000};
         83:   v = {10'd20, 10'd0,  5'b01010};
         84:   v = {10'd21, 10'd0,  5'b11000};
         95:   v = {10'd23, 10'd0,  5'b11010};
         96:   v = {10'd0,  10'd1,  5'b11100};
         540:  v = {10'd15, 10'd5,  5'b11100};
         544:  v = {10'd16, 10'd5,  5'b11000};
         636:  v = {10'd15, 10'd6,  5'b11000};
         767:  v = {10'd23, 10'd7,  5'b11010};
         768:  v = {10'd0,  10'd8,  5'b10000};
         959:  v = {10'd23, 10'd9,  5'b10010};
         960:  v = {10'd0,  10'd10, 5'b11000};
         1151: v = {10'd23, 10'd11, 5'b11010};
         1152: v = {10'd0,  10'd0,  5'b11101};
         1153: v = {10'd0,  10'd0,  5'b11100};
         default: begin v = '0; hit = 0; end
      endcase
      e.tag = 1; e.t = t;
      e.x = v[24:15]; e.y = v[14:5];
      e.hs = v[4]; e.vs = v[3]; e.vo = v[2]; e.pt = v[1]; e.fs = v[0];
      return hit;
   endfunction

   int tcnt = 0;

   task automatic step(input bit r);
      exp_t e;
      reset = r;
      @(posedge clk);
      #1;
      tcnt = r ? 0 : tcnt + 1;
      sb.push_back(model(tcnt, r));
      if (hand(tcnt, e)) sb.push_back(e);
   endtask

   // Stimulus: reset, one full frame plus a little, then a mid-frame reset
   initial begin
      step(1);
      step(1);
      repeat (1160) step(0);
      repeat (300) step(0);
      step(1);
      repeat (20) step(0);
      reset = 0;
      @(posedge clk);
      done = 1;
   end

   // Monitor: drain expectations at the falling edge and compare
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done && sb.size() == 0) begin
            total++;
            if (fs_seen != 1) begin
               bad++;
               $display("FAIL frame_start_count got=%0d want=1", fs_seen);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
         while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({pixel_x, pixel_y, hsync, vsync, video_on, p_tick, frame_start} !==
                {e.x, e.y, e.hs, e.vs, e.vo, e.pt, e.fs}) begin
               bad++;
               $display("FAIL %s t=%0d got x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fs=%b want x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fs=%b",
                        (e.tag == 1) ? "hand" : "model", e.t,
                        pixel_x, pixel_y, hsync, vsync, video_on, p_tick, frame_start,
                        e.x, e.y, e.hs, e.vs, e.vo, e.pt, e.fs);
            end
         end
         if (frame_start === 1'b1) fs_seen++;
      end
   end

endmodule
